// File: rtl/logic_sweep_ctrl_if.sv
// Sweep-controller host/datapath bundle: start/busy/done handshake, operand drive, result sense, error report.
// Latency: none, wires only.
// Backpressure: none; start is simply ignored while the sequencer is busy.
interface logic_sweep_ctrl_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             op_a;
    logic             op_b;
    logic             res_c;
    logic [1:0]       vec_idx;
    logic [ERR_W-1:0] err_cnt;
    logic             first_fail_vld;
    logic [1:0]       first_fail_idx;

    // Sequencer side
    modport master (
        input  start, res_c,
        output busy, done, op_a, op_b, vec_idx, err_cnt, first_fail_vld, first_fail_idx
    );

    // Host plus datapath side
    modport slave (
        output start, res_c,
        input  busy, done, op_a, op_b, vec_idx, err_cnt, first_fail_vld, first_fail_idx
    );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// Built-in self-check sequencer: drives the four a/b vectors, samples c after a settle time, and counts c != a|b.
// Latency: N_PASSES*4*(SETTLE_CYCLES+1) cycles from the start-accept edge to the done pulse.
// Backpressure: start is only sampled in IDLE. Optional first-fail capture is built under LOGIC_SWEEP_FAIL_LOG_EN.
module logic_sweep_ctrl #(
    parameter int N_PASSES      = 1,   // 1..255
    parameter int SETTLE_CYCLES = 1,   // 1..15
    parameter int ERR_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_sweep_ctrl_if.master sw
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [7:0] LAST_PASS   = 8'(N_PASSES - 1);
    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       pass_q, pass_d;
    logic [3:0]       settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             op_a_q, op_a_d;
    logic             op_b_q, op_b_d;

    logic       exp_c;
    logic       mismatch;
    logic       last_vec;
    logic       last_pass;
    logic       settle_end;
    logic       accept;
    logic [1:0] vec_inc;

    // The golden value comes from the vector index, not from the live operand wires.
    assign exp_c      = vec_q[0] | vec_q[1];
    assign mismatch   = (state_q == CHECK) && (sw.res_c != exp_c);
    assign last_vec   = (vec_q == 2'd3);
    assign last_pass  = (pass_q == LAST_PASS);
    assign settle_end = (settle_q == LAST_SETTLE);
    assign accept     = (state_q == IDLE) && sw.start;
    assign vec_inc    = vec_q + 2'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sw.start) state_d = SETTLE;
            SETTLE:  if (settle_end) state_d = CHECK;
            CHECK:   state_d = (last_vec && last_pass) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state alone
    always_comb begin
        sw.busy = (state_q != IDLE);
        sw.done = (state_q == DONE);
    end

    // Next-state for vector, pass, settle and error counters and the operand drive
    always_comb begin
        vec_d    = vec_q;
        pass_d   = pass_q;
        settle_d = settle_q;
        err_d    = err_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        case (state_q)
            IDLE: begin
                if (sw.start) begin
                    vec_d    = 2'd0;
                    pass_d   = 8'd0;
                    settle_d = 4'd0;
                    err_d    = '0;
                    op_a_d   = 1'b0;
                    op_b_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (!settle_end) settle_d = settle_q + 4'd1;
            end
            CHECK: begin
                if (mismatch && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_ONE;
                if (!(last_vec && last_pass)) begin
                    // Index wraps 3 -> 0 by itself; a wrap closes one pass.
                    vec_d    = vec_inc;
                    settle_d = 4'd0;
                    op_a_d   = vec_inc[0];
                    op_b_d   = vec_inc[1];
                    if (last_vec) pass_d = pass_q + 8'd1;
                end
            end
            DONE: begin
                // Park the datapath at vector 0. The error count is kept for the host.
                vec_d  = 2'd0;
                op_a_d = 1'b0;
                op_b_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q    <= 2'd0;
            pass_q   <= 8'd0;
            settle_q <= 4'd0;
            err_q    <= '0;
            op_a_q   <= 1'b0;
            op_b_q   <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            pass_q   <= pass_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

    assign sw.op_a    = op_a_q;
    assign sw.op_b    = op_b_q;
    assign sw.vec_idx = vec_q;
    assign sw.err_cnt = err_q;

`ifdef LOGIC_SWEEP_FAIL_LOG_EN
    logic       ff_vld_q, ff_vld_d;
    logic [1:0] ff_idx_q, ff_idx_d;

    // Keep only the first mismatching vector of a sweep. A new start clears it.
    always_comb begin
        ff_vld_d = ff_vld_q;
        ff_idx_d = ff_idx_q;
        if (accept) begin
            ff_vld_d = 1'b0;
            ff_idx_d = 2'd0;
        end else if (mismatch && !ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_idx_d = vec_q;
        end
    end

    // First-fail capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_vld_q <= 1'b0;
            ff_idx_q <= 2'd0;
        end else begin
            ff_vld_q <= ff_vld_d;
            ff_idx_q <= ff_idx_d;
        end
    end

    assign sw.first_fail_vld = ff_vld_q;
    assign sw.first_fail_idx = ff_idx_q;
`else
    logic unused_accept;
    assign unused_accept     = accept;
    assign sw.first_fail_vld = 1'b0;
    assign sw.first_fail_idx = 2'd0;
`endif
endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: default instance plus a 2-pass, 3-settle, 2-bit-error instance.
// Latency: the scoreboard predicts the done cycle, the error count and the first-fail fields for every start.
// Backpressure: starts are driven only when idle, except for deliberate starts issued while the sweep is busy.
module tb_logic_sweep_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_sweep_ctrl_if #(.ERR_W(8)) if_m ();
    logic_sweep_ctrl_if #(.ERR_W(2)) if_s ();

    // Datapath model modes: 0 good (a|b), 1 c stuck at 0, 2 c stuck at 1
    int mode_m = 0;
    int mode_s = 0;

    function automatic logic dp(int mode, logic a, logic b);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return a | b;
        endcase
    endfunction

    assign if_m.res_c = dp(mode_m, if_m.op_a, if_m.op_b);
    assign if_s.res_c = dp(mode_s, if_s.op_a, if_s.op_b);

    logic_sweep_ctrl #(.N_PASSES(1), .SETTLE_CYCLES(1), .ERR_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (if_m)
    );

    logic_sweep_ctrl #(.N_PASSES(2), .SETTLE_CYCLES(3), .ERR_W(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (if_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int start_cyc;
        int done_cyc;
        int err;
        int ffv;
        int ffi;
    } exp_t;

    exp_t       q_m[$];
    exp_t       q_s[$];
    logic [3:0] opq[$];   // {vec_idx, op_a, op_b} expected per vector of the default instance

    function automatic exp_t predict(int mode, int passes, int errw, int sc, int start_cyc);
        exp_t e;
        int   cnt = 0;
        int   ffv = 0;
        int   ffi = 0;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 4; v++) begin
                logic a, b, c;
                a = logic'(v & 1);
                b = logic'((v >> 1) & 1);
                c = dp(mode, a, b);
                if (c != (a | b)) begin
                    if (cnt < (1 << errw) - 1) cnt++;
                    if (ffv == 0) begin
                        ffv = 1;
                        ffi = v;
                    end
                end
            end
        end
`ifndef LOGIC_SWEEP_FAIL_LOG_EN
        ffv = 0;
        ffi = 0;
`endif
        e.start_cyc = start_cyc;
        e.done_cyc  = start_cyc + passes * 4 * (sc + 1);
        e.err       = cnt;
        e.ffv       = ffv;
        e.ffi       = ffi;
        return e;
    endfunction

    task automatic push_ops;
        opq.push_back(4'b00_00);
        opq.push_back(4'b01_10);
        opq.push_back(4'b10_01);
        opq.push_back(4'b11_11);
    endtask

    // Monitor for the default instance: operand sequence, done timing, results
    logic       prev_busy_m = 1'b0;
    logic [1:0] prev_vec_m  = 2'd0;
    int         busy_run_m  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy_m = 1'b0;
            busy_run_m  = 0;
        end else begin
            if (if_m.busy) busy_run_m++;
            if (if_m.busy && (!prev_busy_m || if_m.vec_idx != prev_vec_m)) begin
                if (opq.size() == 0) begin
                    check("op_seq_unexpected", 1, 0);
                end else begin
                    logic [3:0] eo;
                    eo = opq.pop_front();
                    check("vec_op", {if_m.vec_idx, if_m.op_a, if_m.op_b}, eo);
                end
            end
            if (if_m.done) begin
                if (q_m.size() == 0) begin
                    check("spurious_done_m", 1, 0);
                end else begin
                    exp_t e;
                    e = q_m.pop_front();
                    check("done_cyc_m", cyc, e.done_cyc);
                    check("busy_len_m", busy_run_m, e.done_cyc - e.start_cyc + 1);
                    check("err_cnt_m", if_m.err_cnt, e.err);
                    check("ff_vld_m", if_m.first_fail_vld, e.ffv);
                    check("ff_idx_m", if_m.first_fail_idx, e.ffi);
                end
            end
            if (!if_m.busy && prev_busy_m) check("op_idle_m", {if_m.op_a, if_m.op_b}, 0);
            if (!if_m.busy) busy_run_m = 0;
            prev_busy_m = if_m.busy;
            prev_vec_m  = if_m.vec_idx;
        end
    end

    // Monitor for the saturating instance
    int busy_run_s = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run_s = 0;
        end else begin
            if (if_s.busy) busy_run_s++;
            if (if_s.done) begin
                if (q_s.size() == 0) begin
                    check("spurious_done_s", 1, 0);
                end else begin
                    exp_t e;
                    e = q_s.pop_front();
                    check("done_cyc_s", cyc, e.done_cyc);
                    check("busy_len_s", busy_run_s, e.done_cyc - e.start_cyc + 1);
                    check("err_cnt_s", if_s.err_cnt, e.err);
                    check("ff_vld_s", if_s.first_fail_vld, e.ffv);
                    check("ff_idx_s", if_s.first_fail_idx, e.ffi);
                end
            end
            if (!if_s.busy) busy_run_s = 0;
        end
    end

    task automatic wait_idle_m;
        int n = 0;
        @(negedge clk);
        while (if_m.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached_m", if_m.busy, 0);
    endtask

    task automatic wait_idle_s;
        int n = 0;
        @(negedge clk);
        while (if_s.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached_s", if_s.busy, 0);
    endtask

    // Returns at the negedge right after the accepting edge
    task automatic start_m(input int mode);
        wait_idle_m();
        mode_m = mode;
        q_m.push_back(predict(mode, 1, 8, 1, cyc + 1));
        push_ops();
        if_m.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_m.start = 1'b0;
    endtask

    task automatic start_s(input int mode);
        wait_idle_s();
        mode_s = mode;
        q_s.push_back(predict(mode, 2, 2, 3, cyc + 1));
        if_s.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_s.start = 1'b0;
    endtask

    initial begin
        int n;
        if_m.start = 1'b0;
        if_s.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_m", {if_m.busy, if_m.done, if_m.op_a, if_m.op_b, if_m.vec_idx,
                               if_m.err_cnt, if_m.first_fail_vld, if_m.first_fail_idx}, 0);
        check("reset_outs_s", {if_s.busy, if_s.done, if_s.op_a, if_s.op_b, if_s.vec_idx,
                               if_s.err_cnt, if_s.first_fail_vld, if_s.first_fail_idx}, 0);
        rst_n = 1'b1;

        // Good, stuck-at-0 and stuck-at-1 datapaths on both instances
        start_m(0);
        start_s(2);
        start_m(1);
        start_s(1);
        start_m(2);
        start_s(0);

        // Start held high: a second sweep launches from the IDLE cycle after DONE
        wait_idle_m();
        mode_m = 0;
        q_m.push_back(predict(0, 1, 8, 1, cyc + 1));
        q_m.push_back(predict(0, 1, 8, 1, cyc + 11));
        push_ops();
        push_ops();
        if_m.start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        if_m.start = 1'b0;

        // Starts mid-sweep and in the DONE cycle are ignored; the next IDLE start is taken
        start_m(1);
        repeat (2) @(negedge clk);
        if_m.start = 1'b1;
        @(negedge clk);
        if_m.start = 1'b0;
        n = 0;
        while (!if_m.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_m", if_m.done, 1);
        if_m.start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", if_m.busy, 0);
        mode_m = 0;
        q_m.push_back(predict(0, 1, 8, 1, cyc + 1));
        push_ops();
        @(negedge clk);
        if_m.start = 1'b0;
        check("restart_after_done", if_m.busy, 1);

        // Reset in pass 0 at vector 2 aborts the sweep silently
        wait_idle_s();
        start_m(0);
        n = 0;
        while (if_m.vec_idx != 2'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec2", if_m.vec_idx, 2);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_outs", {if_m.busy, if_m.done, if_m.op_a, if_m.op_b, if_m.vec_idx,
                               if_m.err_cnt, if_m.first_fail_vld, if_m.first_fail_idx}, 0);
        rst_n = 1'b1;
        q_m.delete();
        opq.delete();
        repeat (20) @(negedge clk);
        start_m(0);

        wait_idle_m();
        wait_idle_s();
        repeat (5) @(negedge clk);
        check("sb_empty_m", q_m.size(), 0);
        check("sb_empty_s", q_s.size(), 0);
        check("ops_empty_m", opq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
